// File: rtl/bus_region_router.sv
// Registered bus router: decodes a request against base/mask regions, holds the
// selected slave until it acks or the wait budget runs out, then returns a response.
module bus_region_router #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SLAVES = 4,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = {8'h30, 8'h20, 8'h10, 8'h00},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {8'hF0, 8'hF0, 8'hF0, 8'hF0},
    parameter int TIMEOUT    = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [DATA_WIDTH-1:0]            req_wdata,
    output logic [NUM_SLAVES-1:0]            slv_sel,
    output logic                             slv_write,
    output logic                             slv_read,
    output logic [ADDR_WIDTH-1:0]            slv_addr,
    output logic [DATA_WIDTH-1:0]            slv_wdata,
    input  logic [NUM_SLAVES-1:0]            slv_ack,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slv_rdata,
    output logic                             resp_valid,
    output logic                             resp_err,
    output logic [DATA_WIDTH-1:0]            resp_rdata,
    output logic [7:0]                       err_count
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [NUM_SLAVES-1:0]   sel_q;
    logic                    write_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [CNT_W-1:0]        wait_cnt;
    logic                    resp_err_q;
    logic [DATA_WIDTH-1:0]   resp_rdata_q;
    logic [7:0]              err_count_q;

    logic [NUM_SLAVES-1:0]   hit_sel;
    logic                    hit;
    logic                    ack_sel;
    logic                    timed_out;
    logic [DATA_WIDTH-1:0]   rdata_mux;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Region decode; scanning downward lets the lowest matching index win.
    always_comb begin
        hit_sel = '0;
        hit     = 1'b0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((req_addr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                hit_sel    = '0;
                hit_sel[i] = 1'b1;
                hit        = 1'b1;
            end
        end
    end

    // Only the selected slave's ack and data are visible; sel_q is one-hot or zero.
    always_comb begin
        rdata_mux = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) begin
                rdata_mux = rdata_mux | slv_rdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign ack_sel   = |(slv_ack & sel_q);
    assign timed_out = (wait_cnt == LAST_WAIT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = hit ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                if (ack_sel || timed_out) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wait_cnt     <= '0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            err_count_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        write_q  <= req_write;
                        sel_q    <= hit_sel;
                        wait_cnt <= '0;
                        if (!hit) begin
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                            err_count_q  <= sat_inc(err_count_q);
                        end
                    end
                end
                ACCESS: begin
                    // Ack takes priority over a timeout landing in the same cycle.
                    if (ack_sel) begin
                        sel_q        <= '0;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= write_q ? '0 : rdata_mux;
                    end else if (timed_out) begin
                        sel_q        <= '0;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= '0;
                        err_count_q  <= sat_inc(err_count_q);
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end
                default: begin
                    sel_q <= '0;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign slv_sel    = sel_q;
    assign slv_write  = (state_q == ACCESS) &&  write_q;
    assign slv_read   = (state_q == ACCESS) && !write_q;
    assign slv_addr   = addr_q;
    assign slv_wdata  = wdata_q;
    assign resp_valid = (state_q == RESP);
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_bus_region_router.sv
// Bench for bus_region_router: directed scenarios with a response scoreboard.
module tb_bus_region_router;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [7:0]  req_wdata;
    logic [3:0]  slv_sel;
    logic        slv_write;
    logic        slv_read;
    logic [7:0]  slv_addr;
    logic [7:0]  slv_wdata;
    logic [3:0]  slv_ack;
    logic [31:0] slv_rdata;
    logic        resp_valid;
    logic        resp_err;
    logic [7:0]  resp_rdata;
    logic [7:0]  err_count;

    typedef struct packed {
        logic       err;
        logic [7:0] rdata;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_errs = 8'd0;

    bus_region_router dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .slv_sel    (slv_sel),
        .slv_write  (slv_write),
        .slv_read   (slv_read),
        .slv_addr   (slv_addr),
        .slv_wdata  (slv_wdata),
        .slv_ack    (slv_ack),
        .slv_rdata  (slv_rdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    // Response scoreboard: every resp_valid cycle must match the oldest expectation.
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected: got err=%b rdata=%h, no response expected", resp_err, resp_rdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (resp_err !== e.err || resp_rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL resp_data: got err=%b rdata=%h, want err=%b rdata=%h",
                             resp_err, resp_rdata, e.err, e.rdata);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request, records its expected response, returns just after the handshake edge.
    task automatic issue(input logic wr, input logic [7:0] a, input logic [7:0] d,
                         input logic e_err, input logic [7:0] e_rd);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        exp_q.push_back('{err: e_err, rdata: e_rd});
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++;
        if (req_ready !== 1'b1 || slv_sel !== 4'b0 || resp_valid !== 1'b0 || err_count !== 8'h00 ||
            slv_addr !== 8'h00 || resp_rdata !== 8'h00 || slv_read !== 1'b0 || slv_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b sel=%b rv=%b ec=%h addr=%h rd=%h r=%b w=%b, want 1 0000 0 00 00 00 0 0",
                     req_ready, slv_sel, resp_valid, err_count, slv_addr, resp_rdata, slv_read, slv_write);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read_hit();
        slv_rdata[7:0] = 8'hA5;
        issue(1'b0, 8'h05, 8'h00, 1'b0, 8'hA5);
        checks++;
        if (slv_sel !== 4'b0001 || slv_read !== 1'b1 || slv_write !== 1'b0 || slv_addr !== 8'h05 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL read_access: sel=%b rd=%b wr=%b addr=%h ready=%b, want 0001 1 0 05 0",
                     slv_sel, slv_read, slv_write, slv_addr, req_ready);
        end
        slv_ack = 4'b0001;
        tick();
        slv_ack = 4'b0000;
        checks++;
        if (resp_valid !== 1'b1 || slv_sel !== 4'b0000 || slv_read !== 1'b0) begin
            errors++;
            $display("FAIL read_resp_timing: rv=%b sel=%b rd=%b, want 1 0000 0", resp_valid, slv_sel, slv_read);
        end
        tick();
        checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 8'h00 || resp_err !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL read_resp_clear: rv=%b rd=%h err=%b ready=%b, want 0 00 0 1",
                     resp_valid, resp_rdata, resp_err, req_ready);
        end
    endtask

    task automatic test_write_wait();
        slv_rdata[23:16] = 8'h77;
        issue(1'b1, 8'h2C, 8'h3C, 1'b0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (slv_sel !== 4'b0100 || slv_wdata !== 8'h3C || slv_write !== 1'b1 || slv_read !== 1'b0 || resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL write_hold[%0d]: sel=%b wdata=%h wr=%b rd=%b rv=%b, want 0100 3c 1 0 0",
                         k, slv_sel, slv_wdata, slv_write, slv_read, resp_valid);
            end
            if (k == 3) slv_ack = 4'b0100;
            tick();
        end
        slv_ack = 4'b0000;
        checks++;
        if (resp_valid !== 1'b1 || slv_sel !== 4'b0000 || slv_write !== 1'b0) begin
            errors++;
            $display("FAIL write_resp_timing: rv=%b sel=%b wr=%b, want 1 0000 0", resp_valid, slv_sel, slv_write);
        end
        tick();
    endtask

    task automatic test_unmapped();
        issue(1'b0, 8'h47, 8'h00, 1'b1, 8'h00);
        exp_errs = exp_errs + 8'd1;
        checks++;
        if (resp_valid !== 1'b1 || slv_sel !== 4'b0000 || slv_read !== 1'b0) begin
            errors++;
            $display("FAIL unmapped_resp: rv=%b sel=%b rd=%b, want 1 0000 0", resp_valid, slv_sel, slv_read);
        end
        tick();
        checks++;
        if (err_count !== exp_errs || slv_sel !== 4'b0000 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL unmapped_count: ec=%h sel=%b ready=%b, want %h 0000 1", err_count, slv_sel, req_ready, exp_errs);
        end
    endtask

    task automatic test_timeout();
        issue(1'b0, 8'h1F, 8'h00, 1'b1, 8'h00);
        exp_errs = exp_errs + 8'd1;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (slv_sel !== 4'b0010 || resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL timeout_hold[%0d]: sel=%b rv=%b, want 0010 0", k, slv_sel, resp_valid);
            end
            tick();
        end
        checks++;
        if (resp_valid !== 1'b1 || slv_sel !== 4'b0000) begin
            errors++;
            $display("FAIL timeout_resp: rv=%b sel=%b, want 1 0000", resp_valid, slv_sel);
        end
        slv_ack = 4'b0010;
        tick();
        tick();
        slv_ack = 4'b0000;
        checks++;
        if (err_count !== exp_errs || resp_valid !== 1'b0 || slv_sel !== 4'b0000) begin
            errors++;
            $display("FAIL timeout_late_ack: ec=%h rv=%b sel=%b, want %h 0 0000", err_count, resp_valid, slv_sel, exp_errs);
        end
    endtask

    task automatic test_ack_on_timeout();
        slv_rdata[15:8] = 8'h5A;
        issue(1'b0, 8'h10, 8'h00, 1'b0, 8'h5A);
        for (int k = 0; k < 16; k++) begin
            if (k == 15) slv_ack = 4'b0010;
            tick();
        end
        slv_ack = 4'b0000;
        checks++;
        if (resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL ack_on_timeout_timing: rv=%b, want 1", resp_valid);
        end
        tick();
        checks++;
        if (err_count !== exp_errs) begin
            errors++;
            $display("FAIL ack_on_timeout_count: ec=%h, want %h", err_count, exp_errs);
        end
    endtask

    task automatic test_other_ack_ignored();
        slv_rdata[31:24] = 8'hEE;
        issue(1'b0, 8'h12, 8'h00, 1'b1, 8'h00);
        exp_errs = exp_errs + 8'd1;
        slv_ack = 4'b1000;
        for (int k = 0; k < 16; k++) begin
            if (k == 3) begin
                checks++;
                if (slv_sel !== 4'b0010 || resp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL other_ack_hold: sel=%b rv=%b, want 0010 0", slv_sel, resp_valid);
                end
            end
            tick();
        end
        slv_ack = 4'b0000;
        tick();
        checks++;
        if (err_count !== exp_errs) begin
            errors++;
            $display("FAIL other_ack_count: ec=%h, want %h", err_count, exp_errs);
        end
    endtask

    task automatic test_reset_mid_access();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'h20;
        tick();
        req_valid = 1'b0;
        checks++;
        if (slv_sel !== 4'b0100) begin
            errors++;
            $display("FAIL rst_mid_pre: sel=%b, want 0100", slv_sel);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (slv_sel !== 4'b0000 || slv_read !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0 || err_count !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_async: sel=%b rd=%b ready=%b rv=%b ec=%h, want 0000 0 1 0 00",
                     slv_sel, slv_read, req_ready, resp_valid, err_count);
        end
        exp_errs = 8'd0;
        tick();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || slv_sel !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid_after: rv=%b ready=%b sel=%b, want 0 1 0000", resp_valid, req_ready, slv_sel);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) begin
            issue(1'b0, 8'h47, 8'h00, 1'b1, 8'h00);
            exp_errs = (exp_errs == 8'hFF) ? 8'hFF : exp_errs + 8'd1;
            if (i == 0) begin
                checks++;
                if (req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL sat_ready_in_resp: ready=%b, want 0", req_ready);
                end
            end
            tick();
        end
        checks++;
        if (err_count !== 8'hFF || exp_errs !== 8'hFF) begin
            errors++;
            $display("FAIL saturate: ec=%h, want ff", err_count);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 8'h00;
        req_wdata = 8'h00;
        slv_ack   = 4'b0000;
        slv_rdata = 32'h0;
        test_reset();
        test_read_hit();
        test_write_wait();
        test_unmapped();
        test_timeout();
        test_ack_on_timeout();
        test_other_ack_ignored();
        test_reset_mid_access();
        test_saturate();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
